// File: rtl/apb_mem_slave.sv
// APB-style memory slave: two-phase setup/access handshake, byte strobes,
// fixed wait states, read-only upper region and a saturating error counter.
module apb_mem_slave #(
  parameter int unsigned addrWidth  = 32,
  parameter int unsigned dataWidth  = 32,
  parameter int unsigned Depth      = 256,
  parameter int unsigned RoBase     = 240,
  parameter int unsigned WaitCycles = 2,
  parameter logic [dataWidth-1:0] ResetVal = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sel,
  input  logic                   enable,
  input  logic                   write,
  input  logic [addrWidth-1:0]   addr,
  input  logic [dataWidth-1:0]   wdata,
  input  logic [dataWidth/8-1:0] strb,
  output logic [dataWidth-1:0]   rdata,
  output logic                   ready,
  output logic                   err,
  output logic [7:0]             err_cnt
);

  localparam int unsigned Lanes = dataWidth / 8;
  localparam int unsigned B     = $clog2(Lanes);
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [addrWidth-1:0] AlignMask = addrWidth'((1 << B) - 1);
  localparam logic [addrWidth-1:0] DepthA    = addrWidth'(Depth);
  localparam logic [addrWidth-1:0] RoBaseA   = addrWidth'(RoBase);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e state_q, state_d;

  logic [dataWidth-1:0] mem [Depth];

  logic [3:0]           cnt_q;
  logic                 write_q;
  logic                 err_q;
  logic [IdxW-1:0]      idx_q;
  logic [dataWidth-1:0] wdata_q;
  logic [Lanes-1:0]     strb_q;

  logic [addrWidth-1:0] idx_full;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 read_only;
  logic                 setup;
  logic                 commit_write;

  // Decode of the live bus; only sampled in the setup cycle.
  always_comb begin
    idx_full     = addr >> B;
    misaligned   = (addr & AlignMask) != '0;
    out_of_range = idx_full >= DepthA;
    // RoBase >= Depth never fires on its own: any such index is already out of range.
    read_only    = write && (idx_full >= RoBaseA);
  end

  assign setup = (state_q == IDLE) && sel && !enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ready = (cnt_q == '0) && sel && enable;
        err   = ready && err_q;
        if (!sel || ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (ready && !write_q && !err_q) begin
      rdata = mem[idx_q];
    end
  end

  // Transfer context is frozen at setup; the bus may change freely afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (setup) begin
      cnt_q   <= 4'(WaitCycles);
      write_q <= write;
      err_q   <= misaligned || out_of_range || read_only;
      idx_q   <= idx_full[IdxW-1:0];
      wdata_q <= wdata;
      strb_q  <= strb;
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign commit_write = ready && write_q && !err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < Depth; w++) begin
        mem[w] <= ResetVal;
      end
    end else if (commit_write) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (strb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB-style memory slave, successor to the single-width fixed-wait slave. It adds several features:
- proper two-phase setup/access handshake with sel and enable
- byte-addressed word storage with per-byte write strobes
- a parameter-selected fixed wait-state count
- a read-only upper region
- three error classes and a saturating error counter.

It sits behind the APB master/interconnect as a generic register/memory target for the UVM bench.

Parameters:
addrWidth, 32, address bus width in bits (byte address)
dataWidth, 32, data bus width; must be 8, 16, 32 or 64
Depth, 256, number of dataWidth-bit words stored
RoBase, 240, first read-only word index; words RoBase..Depth-1 reject writes (RoBase >= Depth disables the region)
WaitCycles, 2, wait states inserted in every access phase (0..15)
ResetVal, 0, value loaded into every word on reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
sel  input  1  slave select
enable  input  1  access-phase qualifier
write  input  1  1 = write, 0 = read
addr  input  addrWidth  byte address
wdata  input  dataWidth  write data
strb  input  dataWidth/8  byte write strobes
rdata  output  dataWidth  read data
ready  output  1  transfer completes this cycle
err  output  1  error response, valid only while ready=1
err_cnt  output  8  saturating count of error responses

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=0, err=0, rdata=0, err_cnt=0.
  - All Depth words load ResetVal.
  - Reset takes effect mid-transfer with no write committed.
- Decode (B = log2(dataWidth/8)):
  - index = addr >> B.
  - Error conditions: misaligned (addr[B-1:0] != 0); out of range (index >= Depth); write with index >= RoBase.
  - Priority: misaligned > range > read-only. Any one sets err for the transfer.
- State IDLE:
  - ready=0.
  - On sel=1 & enable=0: latch addr/write/wdata/strb, compute decode, load wait counter = WaitCycles, go to ACCESS.
  - sel=1 & enable=1 in IDLE is a protocol error: ignored, stay IDLE.
- State ACCESS:
  - Counter decrements each cycle while nonzero and saturates at 0. It decrements regardless of enable.
  - ready = (cnt==0) & sel & enable, driven from registered state/counter plus live sel/enable.
  - err = ready & latched error flag.
  - rdata = mem[index] when ready & !write & !err; otherwise 0.
  - Completion: at the rising edge where ready=1:
    - write without error: each byte lane i with strb[i]=1 updates. strb all-zero leaves the word unchanged with no error.
    - err=1: err_cnt increments, saturating at 255.
    - Next state is IDLE.
  - Abort: sel=0 while in ACCESS returns to IDLE next edge. No write is committed, no response is given, err_cnt is unchanged.
  - Latched addr/write/wdata/strb are used for the whole transfer. Bus changes during ACCESS do not alter the transfer.
- Timing:
  - Setup cycle T0; the earliest ready is cycle T0+1+WaitCycles.
  - Back-to-back transfers need a new setup cycle. The minimum period is WaitCycles+2 cycles.
- Read-after-write: a read issued right after a write completes returns the new data.
- Reads ignore strb.
- ready is high for exactly one cycle per completed transfer.

Test Plan:
- Reset, then read addr 0x0 (WaitCycles=2) -> ready first high 3 cycles after setup, rdata=0, err=0, err_cnt=0.
- Write 0xDEADBEEF to 0x10 with strb=4'b1111, then write 0x11223344 to 0x10 with strb=4'b0101, then read 0x10 -> rdata=0xDE22BE44, err=0.
- Read 0x402 (misaligned), read 0x400 (index 256, out of range), write 0x3C0 (index 240, read-only) -> each err=1 with ready; read of 0x3C0 returns 0 (ResetVal); err_cnt=3.
- Write 0x55 to 0x20, then drop sel in the first ACCESS cycle -> no ready pulse; subsequent read of 0x20 returns 0.
- Assert rst_n=0 during the wait states of a write to 0x30 -> outputs zero immediately; after release, read 0x30 returns ResetVal.
- Drive 260 read-only writes -> err_cnt saturates at 255 and holds.
